// File: rtl/jt51_wrq_pkg.sv
// Shared definitions for the JT51 write queue: entry layout and FSM state encoding.
package jt51_wrq_pkg;

  localparam int unsigned EntryW = 16;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAddr = 3'd1,
    StGap  = 3'd2,
    StData = 3'd3,
    StHold = 3'd4,
    StWait = 3'd5
  } wrq_state_e;

endpackage

// File: rtl/jt51_wrqueue_if.sv
// Host push port and register-block replay port of the JT51 write queue.
interface jt51_wrqueue_if #(
  parameter int unsigned AW = 4
);
  logic          cpu_we;
  logic [7:0]    cpu_addr;
  logic [7:0]    cpu_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          clr_ovf;
  logic [7:0]    mmr_din;
  logic          mmr_write;
  logic          mmr_a0;
  logic          mmr_busy;
  logic          idle;

  modport slave (
    input  cpu_we, cpu_addr, cpu_data, clr_ovf, mmr_busy,
    output full, empty, level, overflow, mmr_din, mmr_write, mmr_a0, idle
  );

  modport master (
    output cpu_we, cpu_addr, cpu_data, clr_ovf, mmr_busy,
    input  full, empty, level, overflow, mmr_din, mmr_write, mmr_a0, idle
  );
endinterface

// File: rtl/jt51_wrq_fifo.sv
// Entry storage for the write queue: 2**AW x 16-bit ring with sticky overflow flag.
module jt51_wrq_fifo
  import jt51_wrq_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [EntryW-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              clr_ovf_i,
  output logic [EntryW-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       level_o,
  output logic              overflow_o
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [EntryW-1:0] mem_q [Depth];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              push_ok, pop_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_o = overflow_q;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d   = pop_ok ? rd_ptr_q + PtrOne : rd_ptr_q;
    overflow_d = overflow_q;
    if (push_i && full_o) begin
      overflow_d = 1'b1;
    end else if (clr_ovf_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/jt51_wrqueue.sv
// Host write buffer for the JT51 register block: replays queued (addr, data) pairs
// as address/data writes and waits out the block's busy flag between data writes.
module jt51_wrqueue
  import jt51_wrq_pkg::*;
#(
  parameter int unsigned AW             = 4,
  parameter bit          SKIP_SAME_ADDR = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  jt51_wrqueue_if.slave  bus
);

  logic [EntryW-1:0] head;
  logic              fifo_empty;
  logic              pop;
  logic [7:0]        head_addr, head_data;

  wrq_state_e state_q, state_d;
  logic [7:0] cur_addr_q, cur_addr_d;
  logic [7:0] cur_data_q, cur_data_d;
  logic [7:0] last_addr_q, last_addr_d;
  logic       last_vld_q, last_vld_d;
  logic [7:0] din_q, din_d;
  logic       a0_q, a0_d;
  logic       write_q, write_d;

  jt51_wrq_fifo #(
    .AW (AW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bus.cpu_we),
    .push_data_i ({bus.cpu_addr, bus.cpu_data}),
    .pop_i       (pop),
    .clr_ovf_i   (bus.clr_ovf),
    .head_o      (head),
    .full_o      (bus.full),
    .empty_o     (fifo_empty),
    .level_o     (bus.level),
    .overflow_o  (bus.overflow)
  );

  assign head_addr     = head[15:8];
  assign head_data     = head[7:0];
  assign bus.empty     = fifo_empty;
  assign bus.mmr_din   = din_q;
  assign bus.mmr_a0    = a0_q;
  assign bus.mmr_write = write_q;
  assign bus.idle      = (state_q == StIdle) && fifo_empty;

  // Bus outputs are registered: the value for the next state is loaded on the transition.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    cur_data_d  = cur_data_q;
    last_addr_d = last_addr_q;
    last_vld_d  = last_vld_q;
    din_d       = din_q;
    a0_d        = a0_q;
    write_d     = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          cur_addr_d = head_addr;
          cur_data_d = head_data;
          write_d    = 1'b1;
          if (SKIP_SAME_ADDR && last_vld_q && (head_addr == last_addr_q)) begin
            state_d = StData;
            a0_d    = 1'b1;
            din_d   = head_data;
          end else begin
            state_d = StAddr;
            a0_d    = 1'b0;
            din_d   = head_addr;
          end
        end
      end
      StAddr: begin
        last_addr_d = cur_addr_q;
        last_vld_d  = 1'b1;
        state_d     = StGap;
      end
      // The register block only starts busy on a fresh rising write edge with a0=1.
      StGap: begin
        state_d = StData;
        write_d = 1'b1;
        a0_d    = 1'b1;
        din_d   = cur_data_q;
      end
      StData:  state_d = StHold;
      StHold:  state_d = StWait;
      StWait: begin
        if (!bus.mmr_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      cur_data_q  <= '0;
      last_addr_q <= '0;
      last_vld_q  <= 1'b0;
      din_q       <= '0;
      a0_q        <= 1'b0;
      write_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      cur_data_q  <= cur_data_d;
      last_addr_q <= last_addr_d;
      last_vld_q  <= last_vld_d;
      din_q       <= din_d;
      a0_q        <= a0_d;
      write_q     <= write_d;
    end
  end

endmodule
